// File: rtl/matrix_result_serializer_if.sv
// rtl/matrix_result_serializer_if.sv - result capture and word-stream bundle for matrix_result_serializer
//
// Ports (slave = serializer side):
//   in_valid/in_ready/in_op/C          result capture handshake; C is flattened, element 0 at MSBs
//   out_valid/out_ready/out_data       one element per accepted beat
//   out_idx/out_last                   element index within the result, final-element flag
//   busy                               serializer is streaming a result
interface matrix_result_serializer_if #(
    parameter int word_size = 8,
    parameter int NUM_C     = 16,
    parameter int CNT_W     = $clog2(NUM_C + 1)
);
    logic                         in_valid;
    logic                         in_ready;
    logic [1:0]                   in_op;
    logic [NUM_C*word_size-1:0]   C;
    logic                         out_valid;
    logic                         out_ready;
    logic [word_size-1:0]         out_data;
    logic [CNT_W-1:0]             out_idx;
    logic                         out_last;
    logic                         busy;

    modport master (
        output in_valid, in_op, C, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_op, C, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/matrix_result_serializer.sv
// rtl/matrix_result_serializer.sv - captures a matrix_alu result vector and streams it one word per beat
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset; aborts any stream in progress
//   bus     matrix_result_serializer_if.slave: capture side (in_*, C) and word stream (out_*, busy)
//
// in_op == 2'b11 streams all NUM_C elements of C; any other op streams only the
// low NUM_A elements. Elements leave most-significant word first.
module matrix_result_serializer #(
    parameter int word_size     = 8,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    matrix_result_serializer_if.slave    bus
);
    localparam int NUM_A = Amatrixrownum * Amatrixcolnum;
    localparam int NUM_C = NUM_A * Bmatrixrownum * Bmatrixcolnum;
    localparam int CNT_W = $clog2(NUM_C + 1);
    localparam int VEC_W = NUM_C * word_size;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [VEC_W-1:0]   shreg;
    logic [CNT_W-1:0]   n_reg;
    logic [CNT_W-1:0]   idx_reg;
    logic               last_reg;

    logic [VEC_W-1:0]   slice_sel;
    logic [CNT_W-1:0]   n_sel;
    logic               capture;
    logic               beat;
    logic               at_last;

    // Short ops keep only the low NUM_A words; shifting them up leaves the
    // first element to send in the top word of the shift register.
    always_comb begin
        slice_sel = bus.C;
        n_sel     = CNT_W'(NUM_C);
        if (bus.in_op != 2'b11) begin
            slice_sel = bus.C << ((NUM_C - NUM_A) * word_size);
            n_sel     = CNT_W'(NUM_A);
        end
    end

    assign capture = bus.in_valid && (state == IDLE);
    assign beat    = (state == STREAM) && bus.out_ready;
    assign at_last = (idx_reg == n_reg - CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready && at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg    <= '0;
            n_reg    <= '0;
            idx_reg  <= '0;
            last_reg <= 1'b0;
        end else if (capture) begin
            shreg    <= slice_sel;
            n_reg    <= n_sel;
            idx_reg  <= '0;
            last_reg <= (n_sel == CNT_W'(1));
        end else if (beat) begin
            if (at_last) begin
                idx_reg  <= '0;
                last_reg <= 1'b0;
            end else begin
                shreg    <= shreg << word_size;
                idx_reg  <= idx_reg + CNT_W'(1);
                last_reg <= (idx_reg + CNT_W'(1) == n_reg - CNT_W'(1));
            end
        end
    end

    // Every output is a flop or a decode of the state flop only.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == STREAM);
    assign bus.busy      = (state == STREAM);
    assign bus.out_data  = shreg[VEC_W-1 -: word_size];
    assign bus.out_idx   = idx_reg;
    assign bus.out_last  = last_reg;
endmodule

// File: tb/tb_matrix_result_serializer.sv
// tb/tb_matrix_result_serializer.sv - self-checking bench for matrix_result_serializer
module tb_matrix_result_serializer;
    localparam int W     = 8;
    localparam int NUM_A = 4;
    localparam int NUM_C = 16;
    localparam int CNT_W = 5;

    localparam logic [127:0] C0 = 128'h00112233_445566778899AABB_CCDDEEFF;
    localparam logic [127:0] C1 = 128'hFFEEDDCC_BBAA9988_77665544_10203040;
    localparam logic [127:0] C2 = 128'h01234567_89ABCDEF_0F1E2D3C_50607080;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    matrix_result_serializer_if #(.word_size(W), .NUM_C(NUM_C), .CNT_W(CNT_W)) bus ();

    matrix_result_serializer #(
        .word_size(W),
        .Amatrixrownum(2),
        .Amatrixcolnum(2),
        .Bmatrixrownum(2),
        .Bmatrixcolnum(2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int total  = 0;
    int passed = 0;
    bit cmp_en = 1'b0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a result is a list of words; a stream pops one per accepted beat.
    logic [7:0] m_q[$];
    int         m_idx = 0;
    bit         m_stream = 1'b0;
    int         m_n;

    function automatic logic [7:0] slice_word(input logic [127:0] c, input logic [1:0] op, input int i);
        if (op == 2'b11) return c[(NUM_C-1-i)*W +: W];
        return c[(NUM_A-1-i)*W +: W];
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_idx    = 0;
            m_stream = 1'b0;
        end else if (!m_stream) begin
            if (bus.in_valid) begin
                m_n = (bus.in_op == 2'b11) ? NUM_C : NUM_A;
                for (int i = 0; i < m_n; i++) m_q.push_back(slice_word(bus.C, bus.in_op, i));
                m_idx    = 0;
                m_stream = 1'b1;
            end
        end else if (bus.out_ready) begin
            void'(m_q.pop_front());
            m_idx++;
            if (m_q.size() == 0) m_stream = 1'b0;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", bus.in_ready, !m_stream);
            check("busy", bus.busy, m_stream);
            check("out_valid", bus.out_valid, m_stream);
            if (m_stream) begin
                check("out_data", bus.out_data, m_q[0]);
                check("out_idx", bus.out_idx, m_idx);
                check("out_last", bus.out_last, m_q.size() == 1);
            end else begin
                check("out_last_idle", bus.out_last, 1'b0);
            end
        end
    end

    // Log of accepted beats, used by the hand-computed expectations.
    logic [7:0] got_d[$];
    int         got_i[$];
    bit         got_l[$];
    int         got_c[$];

    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_data);
            got_i.push_back(int'(bus.out_idx));
            got_l.push_back(bus.out_last);
            got_c.push_back(cyc);
        end
    end

    task automatic clear_log();
        got_d.delete();
        got_i.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic offer(input logic [127:0] c, input logic [1:0] op);
        bus.C        = c;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(bus.in_ready && !bus.out_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, k < 200, 1'b1);
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] first, input logic [7:0] step);
        logic [7:0] e;
        check({name, "_count"}, got_d.size(), n);
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            e = first + step * i[7:0];
            check({name, "_data"}, got_d[i], e);
            check({name, "_idx"}, got_i[i], i);
            check({name, "_last"}, got_l[i], i == n - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.C         = '0;
        bus.out_ready = 1'b1;

        #1 resetn = 1'b0;
        #20;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // Full vector: 00,11,...,FF on consecutive cycles
        clear_log();
        offer(C0, 2'b11);
        wait_idle("full_timeout");
        check_log("full", 16, 8'h00, 8'h11);
        if (got_c.size() == 16) check("full_span", got_c[15] - got_c[0], 15);

        // Short op: low four words only
        clear_log();
        @(posedge clk); #1;
        offer(C0, 2'b00);
        wait_idle("short_timeout");
        check_log("short", 4, 8'hCC, 8'h11);

        // Backpressure at out_idx 1 for three cycles
        clear_log();
        @(posedge clk); #1;
        offer(C0, 2'b01);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_data, 8'hDD);
            check("bp_hold_idx", bus.out_idx, 1);
            if (j < 2) @(posedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle("bp_timeout");
        check_log("bp", 4, 8'hCC, 8'h11);

        // in_valid with a new vector during a stream is ignored
        clear_log();
        @(posedge clk); #1;
        offer(C0, 2'b11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.C        = {16{8'hAA}};
        bus.in_valid = 1'b1;
        check("ign_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_idle("ign_timeout");
        check_log("ign", 16, 8'h00, 8'h11);
        repeat (3) @(negedge clk);
        check("ign_no_capture", bus.out_valid, 1'b0);

        // Reset at beat 5 aborts the stream asynchronously
        clear_log();
        @(posedge clk); #1;
        offer(C0, 2'b11);
        k = 0;
        while (bus.out_idx != CNT_W'(5) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reach_beat5", k < 40, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 1'b0);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_out_idx", bus.out_idx, 0);
        check("rst_mid_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        clear_log();
        @(posedge clk); #1;
        offer(128'h01020304, 2'b00);
        wait_idle("rst_after_timeout");
        check_log("rst_after", 4, 8'h01, 8'h01);

        // Back-to-back with in_valid held: 4 beats, one idle cycle, 4 beats
        clear_log();
        @(posedge clk); #1;
        bus.C        = C1;
        bus.in_op    = 2'b10;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.C = C2;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.in_ready && k < 50);
        check("b2b_second_ready", k < 50, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_idle("b2b_timeout");
        check("b2b_count", got_d.size(), 8);
        if (got_d.size() == 8) begin
            for (int i = 0; i < 8; i++) check("b2b_data", got_d[i], 8'h10 * (i + 1));
            check("b2b_span", got_c[7] - got_c[0], 8);
            check("b2b_bubble", got_c[4] - got_c[3], 2);
            check("b2b_idx_restart", got_i[4], 0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
Downstream stage of matrix_alu. Captures the wide flattened result vector C plus the op that produced it, then streams the result out one word per beat over a valid/ready handshake. This frees the ALU output for the next operation and gives later consumers (memory writer, UART/debug port) a narrow, word-wide interface.

Parameters:
word_size, 8, width of one matrix element / output word
Amatrixrownum, 2, rows of A
Amatrixcolnum, 2, columns of A
Bmatrixrownum, 2, rows of B
Bmatrixcolnum, 2, columns of B
(derived) NUM_A = Amatrixrownum*Amatrixcolnum (4); NUM_C = NUM_A*Bmatrixrownum*Bmatrixcolnum (16); CNT_W = $clog2(NUM_C+1)

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  reset; one clock; reset is asynchronous and active-low
in_valid  input  1  C/in_op hold a result to capture
in_ready  output  1  block can accept a result (high only in IDLE)
in_op  input  2  op that produced C; selects element count
C  input  NUM_C*word_size  flattened ALU result, element 0 at MSBs
out_valid  output  1  out_data holds a valid element
out_ready  input  1  consumer accepts element this cycle
out_data  output  word_size  current element
out_idx  output  CNT_W  index of current element within the result, 0-based
out_last  output  1  current element is the final one of the result
busy  output  1  high while streaming (STREAM state)

Behaviour:
- Reset (resetn low, async): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, capture register=0. Reset mid-stream aborts the stream; remaining words are lost.
- Element count N: in_op==2'b11 -> N=NUM_C (full vector); else N=NUM_A, taken from the low NUM_A*word_size bits of C.
- Order: most-significant word of the selected slice first (row-major, element 0 first).
- FSM IDLE: in_ready=1. On in_valid&&in_ready: register selected slice (left-justified into a shift register), N, go STREAM. out_valid rises the cycle after capture (1-cycle latency), out_idx=0.
- FSM STREAM: in_ready=0; in_valid ignored (no capture, no error). out_data/out_idx/out_last stay stable while out_valid&&!out_ready. On out_valid&&out_ready: if out_idx==N-1 -> IDLE, out_valid=0 next cycle; else shift one word, out_idx+1.
- out_last = out_valid && (out_idx==N-1).
- Throughput: with out_ready held high, one word per cycle; N+1 cycles from capture edge to return to IDLE; new capture possible in the IDLE cycle (one idle bubble between results).
- All outputs registered; no combinational path from in_valid or out_ready to any output.
- C/in_op changes after capture have no effect on the stream in progress.

Test Plan:
- Full stream: C=128'h00112233_445566778899AABB_CCDDEEFF, in_op=2'b11, in_valid 1 cycle, out_ready=1 -> 16 beats 00,11,22,...,FF on consecutive cycles, out_idx 0..15, out_last only with FF, then in_ready=1.
- Short op: same C, in_op=2'b00 -> exactly 4 beats CC,DD,EE,FF, out_last on FF, out_idx 0..3.
- Backpressure: in_op=2'b01, out_ready low for 3 cycles at out_idx=1 -> out_data=DD, out_idx=1 held stable all 3 cycles; stream resumes EE,FF with nothing dropped or duplicated.
- Ignored input: in_valid pulsed with new C (all 8'hAA) at beat 2 of a stream -> stream unchanged, in_ready stays 0; AA result not captured.
- Reset mid-stream: assert resetn low at beat 5 of an op=2'b11 stream -> out_valid, busy, out_idx go 0 immediately (async); after release in_ready=1, next capture streams from element 0.
- Back-to-back: two results offered with in_valid held -> second captured in the IDLE cycle after first out_last handshake; total 4+1+4 cycles for two op=2'b10 results.
